// File: rtl/mips_cpu_pkg.sv
// Shared MIPS32 constants: opcodes, functs, REGIMM rt codes,
// encoder mnemonic enum and error codes.
package mips_cpu_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  localparam logic [4:0] RI_BLTZ   = 5'd0;
  localparam logic [4:0] RI_BGEZ   = 5'd1;
  localparam logic [4:0] RI_BLTZAL = 5'd16;
  localparam logic [4:0] RI_BGEZAL = 5'd17;

  typedef enum logic [5:0] {
    M_SLL, M_SRL, M_SRA,
    M_SLLV, M_SRLV, M_SRAV,
    M_JR, M_JALR,
    M_MFHI, M_MTHI,
    M_MFLO, M_MTLO,
    M_MULT, M_MULTU,
    M_DIV, M_DIVU,
    M_ADDU, M_SUBU,
    M_AND, M_OR, M_XOR,
    M_SLT, M_SLTU,
    M_BLTZ, M_BGEZ,
    M_BLTZAL, M_BGEZAL,
    M_J, M_JAL,
    M_BEQ, M_BNE,
    M_BLEZ, M_BGTZ,
    M_ADDIU, M_SLTI, M_SLTIU,
    M_ANDI, M_ORI, M_XORI,
    M_LUI,
    M_LB, M_LH, M_LW,
    M_LBU, M_LHU,
    M_SB, M_SH, M_SW
  } mnem_t;

  typedef enum logic [1:0] {
    ERR_MNEM = 2'd0,
    ERR_IMM  = 2'd1,
    ERR_BR   = 2'd2,
    ERR_JMP  = 2'd3
  } err_t;

  function automatic logic simm_fits(
    input logic [31:0] v
  );
    return v == {{16{v[15]}}, v[15:0]};
  endfunction

  function automatic logic zimm_fits(
    input logic [31:0] v
  );
    return v[31:16] == 16'h0000;
  endfunction

endpackage

// File: rtl/mips_cpu_enc_fifo.sv
// Output FIFO of {addr, data} words for the instruction encoder.
// Ports: push/push_addr/push_data, pop, head_addr/head_data, full, empty.
module mips_cpu_enc_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  logic [31:0] push_addr,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic [31:0] head_addr,
  output logic [31:0] head_data,
  output logic        full,
  output logic        empty
);
  localparam int AW = $clog2(DEPTH);

  logic [63:0] mem [DEPTH];
  logic [AW:0] wp;
  logic [AW:0] rp;
  logic        do_push;
  logic        do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // extra pointer bit tells full from empty
  assign empty = wp == rp;
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + (AW+1)'(1);
      if (do_pop)  rp <= rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wp[AW-1:0]] <= {push_addr, push_data};
  end

  assign {head_addr, head_data} =
    empty ? 64'd0 : mem[rp[AW-1:0]];

endmodule

// File: rtl/mips_cpu_instr_encoder.sv
// Streaming MIPS32 encoder: symbolic requests in, {addr, word} out via FIFO.
// Ports: req_* handshake, word_* handshake, err_valid/err_code/err_count.
// Option: MIPS_ENC_DELAY_SLOT_NOP_EN appends a NOP after branches/jumps.
module mips_cpu_instr_encoder
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hBFC00000,
  parameter int          DEPTH     = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_mnem,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_shamt,
  input  logic [31:0] req_imm,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [31:0] word_data,
  output logic [31:0] word_addr,
  output logic        err_valid,
  output logic [1:0]  err_code,
  output logic [7:0]  err_count
);

  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] boff;
  logic        br_ok;
  logic        j_ok;
  logic        s_ok;
  logic        z_ok;

  logic [5:0]  f_op;
  logic [5:0]  f_fn;
  logic [4:0]  f_rs;
  logic [4:0]  f_rt;
  logic [4:0]  f_rd;
  logic [4:0]  f_sh;
  logic [15:0] f_imm;
  logic        jfmt;
  logic        ctl;
  logic        bad;
  err_t        code;
  logic [31:0] enc_word;

  logic        accept;
  logic        acc_push;
  logic        nop_push;
  logic        push;
  logic        full;
  logic        empty;

  assign pc4  = pc + 32'd4;
  assign boff = 32'($signed(req_imm - pc4) >>> 2);
  assign br_ok = (req_imm[1:0] == 2'b00) &&
                 (&boff[31:15] || ~|boff[31:15]);
  assign j_ok  = (req_imm[1:0] == 2'b00) &&
                 (req_imm[31:28] == pc4[31:28]);
  assign s_ok  = simm_fits(req_imm);
  assign z_ok  = zimm_fits(req_imm);

  always_comb begin
    f_op  = OP_RTYPE;
    f_fn  = FN_SLL;
    f_rs  = req_rs;
    f_rt  = req_rt;
    f_rd  = req_rd;
    f_sh  = 5'd0;
    f_imm = req_imm[15:0];
    jfmt  = 1'b0;
    ctl   = 1'b0;
    bad   = 1'b0;
    code  = ERR_MNEM;
    unique case (req_mnem)
      M_SLL: begin
        f_rs = '0; f_sh = req_shamt; f_fn = FN_SLL;
      end
      M_SRL: begin
        f_rs = '0; f_sh = req_shamt; f_fn = FN_SRL;
      end
      M_SRA: begin
        f_rs = '0; f_sh = req_shamt; f_fn = FN_SRA;
      end
      M_SLLV:  f_fn = FN_SLLV;
      M_SRLV:  f_fn = FN_SRLV;
      M_SRAV:  f_fn = FN_SRAV;
      M_JR: begin
        f_rt = '0; f_rd = '0; f_fn = FN_JR; ctl = 1'b1;
      end
      M_JALR: begin
        f_rt = '0; f_fn = FN_JALR; ctl = 1'b1;
      end
      M_MFHI: begin
        f_rs = '0; f_rt = '0; f_fn = FN_MFHI;
      end
      M_MFLO: begin
        f_rs = '0; f_rt = '0; f_fn = FN_MFLO;
      end
      M_MTHI: begin
        f_rt = '0; f_rd = '0; f_fn = FN_MTHI;
      end
      M_MTLO: begin
        f_rt = '0; f_rd = '0; f_fn = FN_MTLO;
      end
      M_MULT:  begin f_rd = '0; f_fn = FN_MULT;  end
      M_MULTU: begin f_rd = '0; f_fn = FN_MULTU; end
      M_DIV:   begin f_rd = '0; f_fn = FN_DIV;   end
      M_DIVU:  begin f_rd = '0; f_fn = FN_DIVU;  end
      M_ADDU:  f_fn = FN_ADDU;
      M_SUBU:  f_fn = FN_SUBU;
      M_AND:   f_fn = FN_AND;
      M_OR:    f_fn = FN_OR;
      M_XOR:   f_fn = FN_XOR;
      M_SLT:   f_fn = FN_SLT;
      M_SLTU:  f_fn = FN_SLTU;
      M_BLTZ, M_BGEZ, M_BLTZAL, M_BGEZAL: begin
        f_op  = OP_REGIMM;
        f_imm = boff[15:0];
        ctl   = 1'b1;
        bad   = !br_ok;
        code  = ERR_BR;
        unique case (req_mnem)
          M_BLTZ:   f_rt = RI_BLTZ;
          M_BGEZ:   f_rt = RI_BGEZ;
          M_BLTZAL: f_rt = RI_BLTZAL;
          default:  f_rt = RI_BGEZAL;
        endcase
      end
      M_BEQ, M_BNE, M_BLEZ, M_BGTZ: begin
        f_imm = boff[15:0];
        ctl   = 1'b1;
        bad   = !br_ok;
        code  = ERR_BR;
        unique case (req_mnem)
          M_BEQ:  f_op = OP_BEQ;
          M_BNE:  f_op = OP_BNE;
          M_BLEZ: begin f_op = OP_BLEZ; f_rt = '0; end
          default: begin f_op = OP_BGTZ; f_rt = '0; end
        endcase
      end
      M_J, M_JAL: begin
        f_op = (req_mnem == M_J) ? OP_J : OP_JAL;
        jfmt = 1'b1;
        ctl  = 1'b1;
        bad  = !j_ok;
        code = ERR_JMP;
      end
      M_ANDI, M_ORI, M_XORI, M_LUI: begin
        bad  = !z_ok;
        code = ERR_IMM;
        unique case (req_mnem)
          M_ANDI: f_op = OP_ANDI;
          M_ORI:  f_op = OP_ORI;
          M_XORI: f_op = OP_XORI;
          default: begin f_op = OP_LUI; f_rs = '0; end
        endcase
      end
      M_ADDIU, M_SLTI, M_SLTIU,
      M_LB, M_LH, M_LW, M_LBU, M_LHU,
      M_SB, M_SH, M_SW: begin
        bad  = !s_ok;
        code = ERR_IMM;
        unique case (req_mnem)
          M_ADDIU: f_op = OP_ADDIU;
          M_SLTI:  f_op = OP_SLTI;
          M_SLTIU: f_op = OP_SLTIU;
          M_LB:    f_op = OP_LB;
          M_LH:    f_op = OP_LH;
          M_LW:    f_op = OP_LW;
          M_LBU:   f_op = OP_LBU;
          M_LHU:   f_op = OP_LHU;
          M_SB:    f_op = OP_SB;
          M_SH:    f_op = OP_SH;
          default: f_op = OP_SW;
        endcase
      end
      default: begin
        bad  = 1'b1;
        code = ERR_MNEM;
      end
    endcase
  end

  always_comb begin
    if (jfmt)
      enc_word = {f_op, req_imm[27:2]};
    else if (f_op == OP_RTYPE)
      enc_word = {f_op, f_rs, f_rt, f_rd, f_sh, f_fn};
    else
      enc_word = {f_op, f_rs, f_rt, f_imm};
  end

  assign accept   = req_valid && req_ready;
  assign acc_push = accept && !bad;
  assign push     = acc_push || nop_push;

`ifdef MIPS_ENC_DELAY_SLOT_NOP_EN
  typedef enum logic {
    S_IDLE,
    S_NOP_PEND
  } state_t;

  state_t state;
  state_t state_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    nop_push = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (acc_push && ctl) state_nx = S_NOP_PEND;
      end
      S_NOP_PEND: begin
        if (!full) begin
          nop_push = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign req_ready = !full && (state == S_IDLE);
`else
  logic ctl_unused;
  assign ctl_unused = ctl;
  assign nop_push   = 1'b0;
  assign req_ready  = !full;
`endif

  mips_cpu_enc_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_addr (pc),
    .push_data (nop_push ? 32'd0 : enc_word),
    .pop       (word_valid && word_ready),
    .head_addr (word_addr),
    .head_data (word_data),
    .full      (full),
    .empty     (empty)
  );

  assign word_valid = !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc        <= BASE_ADDR;
      err_valid <= 1'b0;
      err_code  <= 2'd0;
      err_count <= 8'd0;
    end else begin
      if (push) pc <= pc4;
      err_valid <= accept && bad;
      if (accept && bad) begin
        err_code <= code;
        if (err_count != 8'hFF)
          err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mips_cpu_instr_encoder.sv
// Scoreboard bench for mips_cpu_instr_encoder.
// Expected {addr, word} and error codes are queued at issue, checked at output.
module tb_mips_cpu_instr_encoder;
  import mips_cpu_pkg::*;

  localparam logic [31:0] BASE = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_mnem = '0;
  logic [4:0]  req_rs = '0;
  logic [4:0]  req_rt = '0;
  logic [4:0]  req_rd = '0;
  logic [4:0]  req_shamt = '0;
  logic [31:0] req_imm = '0;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic [31:0] word_data;
  logic [31:0] word_addr;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  mips_cpu_instr_encoder #(
    .BASE_ADDR (BASE),
    .DEPTH     (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_mnem   (req_mnem),
    .req_rs     (req_rs),
    .req_rt     (req_rt),
    .req_rd     (req_rd),
    .req_shamt  (req_shamt),
    .req_imm    (req_imm),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_data  (word_data),
    .word_addr  (word_addr),
    .err_valid  (err_valid),
    .err_code   (err_code),
    .err_count  (err_count)
  );

  int          n_tests = 0;
  int          n_fail = 0;
  logic [63:0] sbq[$];
  logic [1:0]  errq[$];
  logic [31:0] exp_pc = BASE;
  int          exp_errs = 0;
  logic        nop_model_unused;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [63:0] e;
    if (reset_n && word_valid && word_ready) begin
      chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("word_addr", word_addr, e[63:32]);
        chk("word_data", word_data, e[31:0]);
      end
    end
    if (reset_n && err_valid) begin
      chk("err_nonempty", 32'(errq.size() != 0), 32'd1);
      if (errq.size() != 0)
        chk("err_code", 32'(err_code), 32'(errq.pop_front()));
    end
  end

  task automatic send(input logic [5:0] m,
                      input logic [4:0] rs,
                      input logic [4:0] rt,
                      input logic [4:0] rd,
                      input logic [4:0] sh,
                      input logic [31:0] imm,
                      input logic ok,
                      input logic [31:0] w,
                      input logic [1:0] ec,
                      input logic ctl);
    int n = 0;
    req_mnem  = m;
    req_rs    = rs;
    req_rt    = rt;
    req_rd    = rd;
    req_shamt = sh;
    req_imm   = imm;
    req_valid = 1'b1;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    if (ok) begin
      sbq.push_back({exp_pc, w});
      exp_pc += 32'd4;
`ifdef MIPS_ENC_DELAY_SLOT_NOP_EN
      if (ctl) begin
        sbq.push_back({exp_pc, 32'd0});
        exp_pc += 32'd4;
      end
`else
      nop_model_unused = ctl;
`endif
    end else begin
      errq.push_back(ec);
      if (exp_errs < 255) exp_errs++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    word_ready = 1'b1;
    while ((sbq.size() != 0 || word_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_left", 32'(sbq.size()), 32'd0);
    chk("err_left", 32'(errq.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sbq.delete();
    errq.delete();
    exp_pc = BASE;
    exp_errs = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wvalid", 32'(word_valid), 32'd0);
    chk("rst_wdata", word_data, 32'd0);
    chk("rst_waddr", word_addr, 32'd0);
    chk("rst_evalid", 32'(err_valid), 32'd0);
    chk("rst_ecode", 32'(err_code), 32'd0);
    chk("rst_ecount", 32'(err_count), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("rst_rready", 32'(req_ready), 32'd1);

    send(M_ADDIU, 0, 2, 0, 0, 32'd5, 1, 32'h24020005, 0, 0);
    chk("lat_wvalid", 32'(word_valid), 32'd1);
    word_ready = 1'b1;

    send(M_BEQ, 1, 2, 0, 0, 32'hBFC00010, 1, 32'h10220002, 0, 1);
    send(M_J, 0, 0, 0, 0, 32'hBFC00100, 1, 32'h0BF00040, 0, 1);
    send(M_J, 0, 0, 0, 0, 32'h40000000, 0, 0, 2'd3, 1);
    send(6'd50, 1, 1, 1, 1, 32'd0, 0, 0, 2'd0, 0);
    t = exp_pc + 32'd6;
    send(M_BNE, 1, 2, 0, 0, t, 0, 0, 2'd2, 1);
    t = exp_pc + 32'd4 + 32'h20000;
    send(M_BNE, 1, 2, 0, 0, t, 0, 0, 2'd2, 1);
    t = exp_pc + 32'd4 + 32'h1FFFC;
    send(M_BNE, 1, 2, 0, 0, t, 1, 32'h14227FFF, 0, 1);
    t = exp_pc + 32'd4 - 32'h20000;
    send(M_BNE, 1, 2, 0, 0, t, 1, 32'h14228000, 0, 1);
    send(M_LW, 29, 8, 3, 0, 32'hFFFFFFFC, 1, 32'h8FA8FFFC, 0, 0);
    send(M_LUI, 5, 1, 0, 0, 32'h1234, 1, 32'h3C011234, 0, 0);
    t = exp_pc + 32'd4;
    send(M_BLEZ, 4, 9, 0, 0, t, 1, 32'h18800000, 0, 1);
    t = exp_pc + 32'd12;
    send(M_BGEZAL, 3, 0, 0, 0, t, 1, 32'h04710002, 0, 1);
    send(M_JR, 31, 5, 6, 3, 32'd0, 1, 32'h03E00008, 0, 1);
    send(M_ADDIU, 0, 2, 0, 0, 32'h8000, 0, 0, 2'd1, 0);
    send(M_ADDIU, 0, 2, 0, 0, 32'hFFFF8000, 1, 32'h24028000, 0, 0);
    drain();
    chk("ecount_a", 32'(err_count), 32'(exp_errs));

    do_reset();
    word_ready = 1'b1;
    send(M_SLL, 7, 2, 3, 4, 32'd0, 1, 32'h00021900, 0, 0);
    send(M_ANDI, 0, 1, 0, 0, 32'h00010000, 0, 0, 2'd1, 0);
    drain();
    chk("ecount_b", 32'(err_count), 32'd1);

    do_reset();
    word_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(M_ADDIU, 0, 5'(i), 0, 0, 32'(i),
           1, 32'h24000000 | (i << 16) | i, 0, 0);
    chk("full_rready", 32'(req_ready), 32'd0);
    word_ready = 1'b1;
    #1;
    chk("nobypass_rready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    word_ready = 1'b0;
    chk("pop_rready", 32'(req_ready), 32'd1);
    drain();

    word_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(M_ADDIU, 0, 1, 0, 0, 32'd1, 1, 32'h24010001, 0, 0);
    reset_n = 1'b0;
    #1;
    chk("midrst_wvalid", 32'(word_valid), 32'd0);
    sbq.delete();
    errq.delete();
    exp_pc = BASE;
    exp_errs = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    send(M_ADDIU, 0, 5, 0, 0, 32'd7, 1, 32'h24050007, 0, 0);
    word_ready = 1'b1;
    drain();

    t = exp_pc + 32'd12;
    send(M_BNE, 1, 2, 0, 0, t, 1, 32'h14220002, 0, 1);
`ifdef MIPS_ENC_DELAY_SLOT_NOP_EN
    chk("nop_pend_rready", 32'(req_ready), 32'd0);
`endif
    send(M_ADDIU, 0, 3, 0, 0, 32'd9, 1, 32'h24030009, 0, 0);
    drain();

    for (int i = 0; i < 260; i++)
      send(6'd48 + 6'(i % 16), 0, 0, 0, 0, 32'd0, 0, 0, 2'd0, 0);
    drain();
    chk("ecount_sat", 32'(err_count), 32'd255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
